// File: rtl/apb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_pkg: shared APB state encoding, default widths, request/response bundles
// Revision: 1.0
// ------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2,
        APB_RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DW-1:0] rdata;
        logic              err;
    } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_master_bridge: valid/ready request port to APB3 initiator with pready timeout
// Revision: 1.0
// ------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned AW      = APB_AW,
    parameter int unsigned DW      = APB_DW
) (
    input  logic          apb_pclk,
    input  logic          apb_prstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          apb_psel,
    output logic          apb_penable,
    output logic          apb_pwrite,
    output logic [AW-1:0] apb_paddr,
    output logic [DW-1:0] apb_pwdata,
    input  logic [DW-1:0] apb_prdata,
    input  logic          apb_pready,
    input  logic          apb_pslverr
);

    // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int unsigned CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    apb_state_t    state;
    apb_state_t    state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          accept;
    logic          expire;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        expire    = 1'b0;
        case (state)
            APB_IDLE: begin
                accept = req_valid & req_ready;
                if (accept) state_nxt = APB_SETUP;
            end
            APB_SETUP: state_nxt = APB_ACCESS;
            APB_ACCESS: begin
                expire = (TIMEOUT != 0) && !apb_pready && (wait_cnt == CNT_LAST);
                if (apb_pready || expire) state_nxt = APB_RESP;
            end
            APB_RESP: if (rsp_ready) state_nxt = APB_IDLE;
            default: state_nxt = APB_IDLE;
        endcase
    end

    always_ff @(posedge apb_pclk) begin
        if (!apb_prstn) state <= APB_IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge apb_pclk) begin
        if (!apb_prstn) begin
            req_ready  <= 1'b0;
            apb_pwrite <= 1'b0;
            apb_paddr  <= '0;
            apb_pwdata <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            req_ready <= (state_nxt == APB_IDLE);
            if (accept) begin
                apb_pwrite <= req_write;
                apb_paddr  <= req_addr;
                apb_pwdata <= req_write ? req_wdata : '0;
                wait_cnt   <= '0;
            end
            if (state == APB_ACCESS) begin
                if (apb_pready) begin
                    rsp_err   <= apb_pslverr;
                    rsp_rdata <= (!apb_pwrite && !apb_pslverr) ? apb_prdata : '0;
                end else if (expire) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
            if ((state == APB_RESP) && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    assign apb_psel    = (state == APB_SETUP) || (state == APB_ACCESS);
    assign apb_penable = (state == APB_ACCESS);
    assign rsp_valid   = (state == APB_RESP);

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_apb_master_bridge: transaction-timeline model with per-cycle output compare
// Revision: 1.0
// ------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int TO = 16;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    always #5 clk = ~clk;

    apb_master_bridge #(.TIMEOUT(TO), .AW(AW), .DW(DW)) dut (
        .apb_pclk(clk), .apb_prstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
        .apb_paddr(paddr), .apb_pwdata(pwdata),
        .apb_prdata(prdata), .apb_pready(pready), .apb_pslverr(pslverr)
    );

    int errors = 0;
    int checks = 0;

    // Expected view of the current cycle, written by the driver only.
    logic          e_check = 1'b0, e_zero = 1'b0;
    logic          e_ready, e_psel, e_pen, e_rspv;
    logic          e_write, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    int            accept_id = 0;
    int            pin_id = 0;
    int            pin_acc, pin_first;
    logic [DW-1:0] pin_rdata;
    logic          pin_err;

    // Measurements, owned by the compare process.
    int            seen_acc_id = 0, seen_pin_id = 0;
    int            acc_cycles = 0, since_acc = 0, first_rsp = -1;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (pin_id != seen_pin_id) begin
            seen_pin_id = pin_id;
            chk("pin_access_cycles", 64'(acc_cycles), 64'(pin_acc));
            chk("pin_rsp_latency", 64'(first_rsp), 64'(pin_first));
            chk("pin_rdata", 64'(last_rdata), 64'(pin_rdata));
            chk("pin_err", 64'(last_err), 64'(pin_err));
        end
        if (accept_id != seen_acc_id) begin
            seen_acc_id = accept_id;
            acc_cycles  = 0;
            since_acc   = 0;
            first_rsp   = -1;
        end
        if (e_check) begin
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("psel", 64'(psel), 64'(e_psel));
            chk("penable", 64'(penable), 64'(e_pen));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rspv));
            if (e_zero) begin
                chk("rst_paddr", 64'(paddr), 64'd0);
                chk("rst_pwdata", 64'(pwdata), 64'd0);
                chk("rst_pwrite", 64'(pwrite), 64'd0);
                chk("rst_rdata", 64'(rsp_rdata), 64'd0);
                chk("rst_err", 64'(rsp_err), 64'd0);
            end
            if (e_psel) begin
                chk("pwrite", 64'(pwrite), 64'(e_write));
                chk("paddr", 64'(paddr), 64'(e_addr));
                chk("pwdata", 64'(pwdata), 64'(e_wdata));
            end
            if (e_rspv) begin
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e_err));
            end
        end
        if (penable === 1'b1) acc_cycles++;
        if (rsp_valid === 1'b1 && first_rsp < 0) first_rsp = since_acc;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
        since_acc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_phase(input logic rdy, input logic sel, input logic en, input logic rv);
        e_ready = rdy; e_psel = sel; e_pen = en; e_rspv = rv;
    endtask

    // Inputs the bridge must ignore in the current phase get random values.
    task automatic junk_req();
        req_valid = 1'($urandom); req_write = 1'($urandom);
        req_addr  = $urandom;     req_wdata = $urandom;
    endtask

    task automatic junk_apb();
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    endtask

    task automatic pin(input int acc, input int first, input logic [DW-1:0] rd, input logic err);
        pin_acc = acc; pin_first = first; pin_rdata = rd; pin_err = err;
        pin_id++;
    endtask

    // One request: gap idle cycles, accept, setup, `waits` not-ready access cycles,
    // then response held for `rdelay` cycles. rst_at >= 0 pulses reset in that access cycle.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input logic slverr, input int waits,
                           input int rdelay, input int gap, input int rst_at);
        int  n;
        logic tmo;
        repeat (gap) begin
            req_valid = 1'b0; junk_apb(); rsp_ready = 1'($urandom);
            expect_phase(1, 0, 0, 0);
            tick();
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        junk_apb(); rsp_ready = 1'($urandom);
        expect_phase(1, 0, 0, 0);
        accept_id++;
        tick();
        e_write = wr; e_addr = addr; e_wdata = wr ? wd : '0;
        junk_req(); junk_apb();
        expect_phase(0, 1, 0, 0);
        tick();
        tmo = (TO != 0) && (waits >= TO);
        n   = tmo ? TO : waits + 1;
        for (int i = 0; i < n; i++) begin
            junk_req(); rsp_ready = 1'($urandom);
            pready  = (i == waits);
            prdata  = pready ? rd : $urandom;
            pslverr = pready ? slverr : 1'($urandom);
            expect_phase(0, 1, 1, 0);
            if (i == rst_at) begin
                rstn = 1'b0;
                tick();
                rstn = 1'b1; junk_req(); junk_apb();
                e_zero = 1'b1; expect_phase(0, 0, 0, 0);
                tick();
                e_zero = 1'b0;
                return;
            end
            tick();
        end
        e_err   = tmo | slverr;
        e_rdata = (!wr && !e_err) ? rd : '0;
        for (int j = 0; j <= rdelay; j++) begin
            junk_req(); junk_apb();
            rsp_ready = (j == rdelay);
            expect_phase(0, 0, 0, 1);
            tick();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        tick();
        e_zero = 1'b1; e_check = 1'b1; expect_phase(0, 0, 0, 0);
        tick();
        rstn = 1'b1;
        tick();
        e_zero = 1'b0;

        // Directed cases with hand-computed latency / data.
        run_txn(1, 32'h44, 32'hA5A5_0001, 32'hDEAD_BEEF, 0, 0, 0, 1, -1);
        pin(1, 3, 32'h0, 1'b0);
        run_txn(0, 32'h48, 32'h1111_1111, 32'h0000_0002, 0, 3, 0, 0, -1);
        pin(4, 6, 32'h2, 1'b0);
        run_txn(0, 32'h4C, 32'h0, 32'h5555_AAAA, 1, 1, 0, 0, -1);
        pin(2, 4, 32'h0, 1'b1);
        run_txn(0, 32'h50, 32'h0, 32'h7777_0000, 0, 40, 0, 0, -1);
        pin(16, 18, 32'h0, 1'b1);
        run_txn(0, 32'h54, 32'h0, 32'h0000_1234, 0, 15, 0, 0, -1);
        pin(16, 18, 32'h1234, 1'b0);
        run_txn(1, 32'h58, 32'hCAFE_F00D, 32'h0, 0, 0, 5, 0, -1);
        pin(1, 3, 32'h0, 1'b0);
        run_txn(0, 32'h60, 32'h0, 32'h9999_9999, 0, 3, 0, 0, 2);
        run_txn(0, 32'h64, 32'h0, 32'hABCD_0123, 0, 0, 0, 0, -1);
        pin(1, 3, 32'hABCD_0123, 1'b0);
        run_txn(1, 32'h68, 32'h0BAD_0BAD, 32'h0, 0, 0, 0, 0, -1);
        run_txn(1, 32'h6C, 32'h1234_5678, 32'h0, 1, 0, 0, 0, -1);
        pin(1, 3, 32'h0, 1'b1);

        for (int k = 0; k < 250; k++) begin
            int w;
            int ra;
            w  = ($urandom_range(0, 5) == 0) ? $urandom_range(12, 24) : $urandom_range(0, 4);
            ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
            run_txn(1'($urandom), $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0),
                    w, $urandom_range(0, 3), $urandom_range(0, 2), ra);
        end

        req_valid = 1'b0; expect_phase(1, 0, 0, 0);
        tick();
        tick();
        e_check = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
